// File: rtl/seq_adder.sv
// Multi-cycle ripple adder: sum = a + b + cin over WIDTH bits, STEP bits per clock.
// Define SEQ_ADDER_OVF_EN to add the signed-overflow output ovf.

module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module seq_adder #(
   parameter int WIDTH = 16,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SEQ_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int N  = WIDTH / STEP;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t state, state_nx;
   logic [IW-1:0] idx;
   logic carry;
   logic load, last;

   // Operands and partial result viewed as N slices of STEP bits
   logic [N-1:0][STEP-1:0] a_r, b_r, part, part_nx;
   logic [STEP-1:0] a_sl, b_sl, s_sl;
   logic [STEP:0]   c;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (idx == LAST) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load = (state == IDLE) && start;
      last = (state == RUN) && (idx == LAST);
      busy = (state == RUN);
   end

   assign a_sl = a_r[idx];
   assign b_sl = b_r[idx];
   assign c[0] = carry;

   fa_cell u_fa [STEP-1:0] (
      .a  (a_sl),
      .b  (b_sl),
      .ci (c[STEP-1:0]),
      .s  (s_sl),
      .co (c[STEP:1])
   );

   // Final slice is merged combinationally so sum updates on the same edge
   always_comb begin
      part_nx      = part;
      part_nx[idx] = s_sl;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx   <= '0;
         carry <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         done <= last;
         if (load) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            part  <= '0;
            idx   <= '0;
         end else if (state == RUN) begin
            part  <= part_nx;
            carry <= c[STEP];
            idx   <= last ? '0 : idx + 1'b1;
            if (last) begin
               sum  <= part_nx;
               cout <= c[STEP];
`ifdef SEQ_ADDER_OVF_EN
               ovf  <= (a_r[N-1][STEP-1] == b_r[N-1][STEP-1]) &&
                       (part_nx[N-1][STEP-1] != a_r[N-1][STEP-1]);
`endif
            end
         end
      end
   end
endmodule
